// File: rtl/sha256_block_ctrl_if.sv
// rtl/sha256_block_ctrl_if.sv - block start/abort control and message-word stream handshake
interface sha256_block_ctrl_if;
   logic start;
   logic first_blk;
   logic last_blk;
   logic abort;
   logic ready;
   logic w_valid;
   logic w_ready;

   modport master (
      output start, first_blk, last_blk, abort, w_valid,
      input  ready, w_ready
   );

   modport slave (
      input  start, first_blk, last_blk, abort, w_valid,
      output ready, w_ready
   );
endinterface

// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - sequencer for one SHA-256 compression pass over a 512-bit block
module sha256_block_ctrl #(
   parameter int ROUNDS    = 64,
   parameter int MSG_WORDS = 16,
   parameter int CNT_W     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   sha256_block_ctrl_if.slave ctl,
   output logic [CNT_W-1:0]  round_o,
   output logic              w_src_sel_o,
   output logic              round_en_o,
   output logic              h_init_o,
   output logic              ab_load_o,
   output logic              h_update_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              digest_valid_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_LOAD,
      S_ROUND,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   round_q, round_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic               dv_q, dv_d;

   logic               ready, w_ready, w_src_sel, round_en;
   logic               h_init, ab_load, h_update, done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         round_q <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         first_q <= first_d;
         last_q  <= last_d;
         dv_q    <= dv_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      first_d   = first_q;
      last_d    = last_q;
      dv_d      = dv_q;
      ready     = 1'b0;
      w_ready   = 1'b0;
      w_src_sel = 1'b0;
      round_en  = 1'b0;
      h_init    = 1'b0;
      ab_load   = 1'b0;
      h_update  = 1'b0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (ctl.start) begin
               first_d = ctl.first_blk;
               last_d  = ctl.last_blk;
               dv_d    = 1'b0;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            // A chained block leaves H untouched so it starts from the previous digest.
            h_init  = first_q;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            ab_load = 1'b1;
            round_d = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (round_q < CNT_W'(MSG_WORDS)) begin
               w_ready  = 1'b1;
               round_en = ctl.w_valid;
            end else begin
               w_src_sel = 1'b1;
               round_en  = 1'b1;
            end
            if (round_en) begin
               if (round_q == CNT_W'(ROUNDS - 1)) begin
                  round_d = '0;
                  state_d = S_UPDATE;
               end else begin
                  round_d = round_q + CNT_W'(1);
               end
            end
         end
         S_UPDATE: begin
            h_update = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            dv_d    = last_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort squashes every strobe of the current cycle, including the H accumulate.
      if (ctl.abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         round_d  = '0;
         dv_d     = 1'b0;
         w_ready  = 1'b0;
         round_en = 1'b0;
         h_init   = 1'b0;
         ab_load  = 1'b0;
         h_update = 1'b0;
         done     = 1'b0;
      end
   end

   assign ctl.ready      = ready;
   assign ctl.w_ready    = w_ready;
   assign round_o        = round_q;
   assign w_src_sel_o    = w_src_sel;
   assign round_en_o     = round_en;
   assign h_init_o       = h_init;
   assign ab_load_o      = ab_load;
   assign h_update_o     = h_update;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = done;
   assign digest_valid_o = dv_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb/tb_sha256_block_ctrl.sv - randomized self-checking bench with SHA-256 reference and datapath model
module tb_sha256_block_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sha256_block_ctrl_if bus ();

   logic [5:0] round;
   logic       w_src_sel, round_en, h_init, ab_load, h_update, busy, done, digest_valid;

   sha256_block_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ctl            (bus),
      .round_o        (round),
      .w_src_sel_o    (w_src_sel),
      .round_en_o     (round_en),
      .h_init_o       (h_init),
      .ab_load_o      (ab_load),
      .h_update_o     (h_update),
      .busy_o         (busy),
      .done_o         (done),
      .digest_valid_o (digest_valid)
   );

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   logic [31:0]  blk_w [16];
   logic [31:0]  wm [64];
   logic [255:0] hm, wv, ref_h;
   bit           exp_dv     = 1'b0;
   bit           need_first = 1'b1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [255:0] step(input logic [255:0] s, input logic [31:0] k, input logic [31:0] wt);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin);
      logic [31:0]  w [64];
      logic [255:0] s;
      s = hin;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = blk_w[t];
         else        w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
         s = step(s, K[t], w[t]);
      end
      return add8(hin, s);
   endfunction

   task automatic run_block(input bit first, input bit last, input int st_at, input int st_len,
                            input int ab_cyc, input int sp_cyc);
      int cyc = 0, sent = 0, stall_left = st_len, stalls;
      int n_init = 0, init_at = -1, load_at = -1, n_ren = 0, n_wr = 0, seq_err = 0;
      int n_upd = 0, upd_at = -1, n_done = 0, done_at = -1, multi = 0, stall_err = 0, exp_rnd = 0;
      bit fin = 1'b0, vld;
      logic [31:0] wt;
      logic [5:0]  r;
      stalls = (st_len > 0 && st_at < 16) ? st_len : 0;
      while (!fin && cyc < 300) begin
         @(negedge clk);
         bus.start     = (cyc == 0) || (cyc == sp_cyc);
         bus.first_blk = (cyc == 0) ? first : 1'($urandom_range(0, 1));
         bus.last_blk  = (cyc == 0) ? last  : 1'($urandom_range(0, 1));
         bus.abort     = (cyc == ab_cyc);
         if (sent < 16) vld = !(sent == st_at && stall_left > 0);
         else           vld = 1'($urandom_range(0, 1));
         bus.w_valid = vld;
         #1;
         if (cyc == 0) begin
            check("ready_at_start", bus.ready, 1);
            check("dv_before_start", digest_valid, exp_dv);
         end
         if (cyc == 1) check("dv_cleared", digest_valid, 0);
         if (int'(h_init) + int'(ab_load) + int'(round_en) + int'(h_update) > 1) multi++;
         if (h_init) begin n_init++; init_at = cyc; hm = IV; end
         if (ab_load) begin load_at = cyc; wv = hm; end
         if (round_en) begin
            r = round;
            if (int'(round) != exp_rnd) seq_err++;
            exp_rnd++;
            n_ren++;
            if (!w_src_sel) wt = (sent < 16) ? blk_w[sent] : 32'h0;
            else wt = ssig1(wm[r - 6'd2]) + wm[r - 6'd7] + ssig0(wm[r - 6'd15]) + wm[r - 6'd16];
            wm[r] = wt;
            wv = step(wv, K[r], wt);
         end
         if (bus.w_ready) begin
            n_wr++;
            if (vld) sent++;
            else begin
               stall_left--;
               if (int'(round) != st_at || round_en) stall_err++;
            end
         end
         if (h_update) begin n_upd++; upd_at = cyc; hm = add8(hm, wv); end
         if (done) begin n_done++; done_at = cyc; end
         if (ab_cyc >= 0 && cyc == ab_cyc + 1) begin
            check("abort_ready", bus.ready, 1);
            check("abort_round", round, 0);
            check("abort_dv", digest_valid, 0);
            fin = 1'b1;
         end
         if (ab_cyc < 0 && done) fin = 1'b1;
         cyc++;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (ab_cyc < 0) begin
         check("h_init_count", n_init, first);
         if (first) check("h_init_cycle", init_at, 1);
         check("ab_load_cycle", load_at, 2);
         check("round_en_count", n_ren, 64);
         check("round_sequence", seq_err, 0);
         check("w_ready_count", n_wr, 16 + stalls);
         check("stall_behaviour", stall_err, 0);
         check("h_update_count", n_upd, 1);
         check("h_update_cycle", upd_at, 67 + stalls);
         check("done_count", n_done, 1);
         check("done_cycle", done_at, 68 + stalls);
         check("strobe_exclusive", multi, 0);
         ref_h = compress(first ? IV : ref_h);
         check("digest", hm, ref_h);
         exp_dv     = last;
         need_first = 1'b0;
      end else begin
         check("abort_no_update", n_upd, 0);
         check("abort_no_done", n_done, 0);
         exp_dv     = 1'b0;
         need_first = 1'b1;
      end
   endtask

   task automatic rand_words();
      for (int i = 0; i < 16; i++) blk_w[i] = $urandom;
   endtask

   initial begin
      bit f, l;
      int ab, sp;
      bus.start = 1'b0; bus.first_blk = 1'b0; bus.last_blk = 1'b0;
      bus.abort = 1'b0; bus.w_valid = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", bus.ready, 1);
      check("rst_busy", busy, 0);
      check("rst_round", round, 0);
      check("rst_dv", digest_valid, 0);
      check("rst_strobes", {round_en, h_init, ab_load, h_update, done, bus.w_ready}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // "abc" single-block message
      for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
      blk_w[0] = 32'h61626380; blk_w[15] = 32'h00000018;
      run_block(1, 1, 0, 0, -1, -1);
      check("abc_digest", hm,
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

      // abort while idle must not disturb the held digest
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      check("idle_abort_ready", bus.ready, 1);
      check("idle_abort_dv", digest_valid, 1);

      // two-block reference message
      for (int i = 0; i < 14; i++) blk_w[i] = 32'h61626364 + 32'h01010101 * i;
      blk_w[14] = 32'h80000000; blk_w[15] = 32'h0;
      run_block(1, 0, 0, 0, -1, -1);
      for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
      blk_w[15] = 32'h000001c0;
      run_block(0, 1, 0, 0, -1, -1);
      check("two_block_digest", hm,
            256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

      rand_words();
      run_block(1, 1, 5, 3, -1, -1);
      rand_words();
      run_block(1, 0, 0, 0, 43, -1);
      rand_words();
      run_block(1, 1, 0, 0, -1, 23);
      rand_words();
      run_block(0, 1, 0, 0, -1, -1);

      // asynchronous reset in the middle of round 30
      @(negedge clk);
      bus.start = 1'b1; bus.first_blk = 1'b1; bus.last_blk = 1'b1; bus.w_valid = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #1;
      check("pre_reset_round", round, 30);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ready", bus.ready, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_round", round, 0);
      check("async_rst_strobes", {round_en, h_init, ab_load, h_update, done, bus.w_ready, digest_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", bus.ready, 1);
      check("post_rst_round", round, 0);
      exp_dv     = 1'b0;
      need_first = 1'b1;

      for (int i = 0; i < 8; i++) begin
         rand_words();
         f  = need_first ? 1'b1 : 1'($urandom_range(0, 1));
         l  = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 68)) : -1;
         sp = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 66)) : -1;
         run_block(f, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), ab, sp);
      end

      @(negedge clk);
      #1;
      check("final_dv", digest_valid, exp_dv);
      check("final_ready", bus.ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
